// File: rtl/flattening_module_pkg.sv
// Shared constants and element type for the flattening stage that turns
// pooled feature maps into a single vector.
package flattening_module_pkg;

    localparam int unsigned DEF_NUM_FEATURES      = 10;
    localparam int unsigned DEF_POOLED_HEIGHT     = 10;
    localparam int unsigned DEF_POOLED_WIDTH      = 10;
    localparam int unsigned CONVOLUTION_DATA_WIDTH = 8;

    typedef logic [CONVOLUTION_DATA_WIDTH-1:0] conv_elem_t;

    // Feature-major, then row, then column.
    function automatic int flat_index(input int f, input int r, input int c,
                                      input int height, input int width);
        return f * height * width + r * width + c;
    endfunction

endpackage

// File: rtl/flattening_module_map.sv
// Purely combinational permutation of a [feature][row][col] cube into a
// flat vector; wiring only, no arithmetic on the element values.
module flatten_map #(
    parameter int unsigned NUM_FEATURES           = 10,
    parameter int unsigned POOLED_HEIGHT          = 10,
    parameter int unsigned POOLED_WIDTH           = 10,
    parameter int unsigned FLATTENED_LENGTH       = NUM_FEATURES * POOLED_HEIGHT * POOLED_WIDTH,
    parameter int unsigned CONVOLUTION_DATA_WIDTH = 8
) (
    input  logic [CONVOLUTION_DATA_WIDTH-1:0] pooled_outfmap [NUM_FEATURES][POOLED_HEIGHT][POOLED_WIDTH],
    output logic [CONVOLUTION_DATA_WIDTH-1:0] flattened_outfmap_c [FLATTENED_LENGTH]
);
    import flattening_module_pkg::*;

    for (genvar f = 0; f < NUM_FEATURES; f++) begin : g_feat
        for (genvar r = 0; r < POOLED_HEIGHT; r++) begin : g_row
            for (genvar c = 0; c < POOLED_WIDTH; c++) begin : g_col
                assign flattened_outfmap_c[flat_index(f, r, c, POOLED_HEIGHT, POOLED_WIDTH)] =
                    pooled_outfmap[f][r][c];
            end
        end
    end

endmodule

// File: rtl/flattening_module.sv
// Flattening stage: combinational flattened view plus a capture register
// loaded on flatten_start, with a one-cycle done pulse per capture.
module flattening_module #(
    parameter int unsigned NUM_FEATURES           = flattening_module_pkg::DEF_NUM_FEATURES,
    parameter int unsigned POOLED_HEIGHT          = flattening_module_pkg::DEF_POOLED_HEIGHT,
    parameter int unsigned POOLED_WIDTH           = flattening_module_pkg::DEF_POOLED_WIDTH,
    parameter int unsigned FLATTENED_LENGTH       = NUM_FEATURES * POOLED_HEIGHT * POOLED_WIDTH,
    parameter int unsigned CONVOLUTION_DATA_WIDTH = flattening_module_pkg::CONVOLUTION_DATA_WIDTH
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              flatten_start,
    input  logic [CONVOLUTION_DATA_WIDTH-1:0] pooled_outfmap [NUM_FEATURES][POOLED_HEIGHT][POOLED_WIDTH],
    output logic [CONVOLUTION_DATA_WIDTH-1:0] flattened_outfmap_c [FLATTENED_LENGTH],
    output logic [CONVOLUTION_DATA_WIDTH-1:0] flattened_outfmap [FLATTENED_LENGTH],
    output logic                              flatten_done
);
    import flattening_module_pkg::*;

    if (FLATTENED_LENGTH != NUM_FEATURES * POOLED_HEIGHT * POOLED_WIDTH) begin : g_bad_length
        $error("flattening_module: FLATTENED_LENGTH must equal NUM_FEATURES*POOLED_HEIGHT*POOLED_WIDTH");
    end

    logic [CONVOLUTION_DATA_WIDTH-1:0] flattened_d [FLATTENED_LENGTH];
    logic [CONVOLUTION_DATA_WIDTH-1:0] flattened_q [FLATTENED_LENGTH];
    logic                              done_d;
    logic                              done_q;

    flatten_map #(
        .NUM_FEATURES          (NUM_FEATURES),
        .POOLED_HEIGHT         (POOLED_HEIGHT),
        .POOLED_WIDTH          (POOLED_WIDTH),
        .FLATTENED_LENGTH      (FLATTENED_LENGTH),
        .CONVOLUTION_DATA_WIDTH(CONVOLUTION_DATA_WIDTH)
    ) u_map (
        .pooled_outfmap     (pooled_outfmap),
        .flattened_outfmap_c(flattened_outfmap_c)
    );

    always_comb begin
        flattened_d = flattened_q;
        done_d      = flatten_start;
        if (flatten_start) begin
            flattened_d = flattened_outfmap_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < FLATTENED_LENGTH; i++) begin
                flattened_q[i] <= '0;
            end
            done_q <= 1'b0;
        end else begin
            flattened_q <= flattened_d;
            done_q      <= done_d;
        end
    end

    assign flattened_outfmap = flattened_q;
    assign flatten_done      = done_q;

endmodule

// File: tb/tb_flattening_module.sv
// Randomized bench for flattening_module: default-size and non-square
// instances checked against a queue-based flattening model.
module tb_flattening_module;
    import flattening_module_pkg::*;

    localparam int NF  = 10;
    localparam int PH  = 10;
    localparam int PW  = 10;
    localparam int FL  = NF * PH * PW;
    localparam int SNF = 3;
    localparam int SPH = 2;
    localparam int SPW = 5;
    localparam int SFL = SNF * SPH * SPW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start;
    logic       s_start;
    conv_elem_t pooled   [NF][PH][PW];
    conv_elem_t flat_c   [FL];
    conv_elem_t flat_r   [FL];
    logic       done;
    conv_elem_t s_pooled [SNF][SPH][SPW];
    conv_elem_t s_flat_c [SFL];
    conv_elem_t s_flat_r [SFL];
    logic       s_done;

    conv_elem_t exp_r   [FL];
    conv_elem_t s_exp_r [SFL];

    int total = 0;
    int bad   = 0;

    flattening_module #(
        .NUM_FEATURES          (NF),
        .POOLED_HEIGHT         (PH),
        .POOLED_WIDTH          (PW),
        .FLATTENED_LENGTH      (FL),
        .CONVOLUTION_DATA_WIDTH(8)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .flatten_start      (start),
        .pooled_outfmap     (pooled),
        .flattened_outfmap_c(flat_c),
        .flattened_outfmap  (flat_r),
        .flatten_done       (done)
    );

    flattening_module #(
        .NUM_FEATURES          (SNF),
        .POOLED_HEIGHT         (SPH),
        .POOLED_WIDTH          (SPW),
        .FLATTENED_LENGTH      (SFL),
        .CONVOLUTION_DATA_WIDTH(8)
    ) dut_small (
        .clk                (clk),
        .rst_n              (rst_n),
        .flatten_start      (s_start),
        .pooled_outfmap     (s_pooled),
        .flattened_outfmap_c(s_flat_c),
        .flattened_outfmap  (s_flat_r),
        .flatten_done       (s_done)
    );

    // Reading the cube in natural nested order yields the flattened vector.
    function automatic void model_flat(input conv_elem_t p [NF][PH][PW], output conv_elem_t v [FL]);
        conv_elem_t q[$];
        for (int f = 0; f < NF; f++)
            for (int r = 0; r < PH; r++)
                for (int c = 0; c < PW; c++)
                    q.push_back(p[f][r][c]);
        for (int i = 0; i < FL; i++) v[i] = q[i];
    endfunction

    function automatic void s_model_flat(input conv_elem_t p [SNF][SPH][SPW], output conv_elem_t v [SFL]);
        conv_elem_t q[$];
        for (int f = 0; f < SNF; f++)
            for (int r = 0; r < SPH; r++)
                for (int c = 0; c < SPW; c++)
                    q.push_back(p[f][r][c]);
        for (int i = 0; i < SFL; i++) v[i] = q[i];
    endfunction

    task automatic randomize_pooled();
        for (int f = 0; f < NF; f++)
            for (int r = 0; r < PH; r++)
                for (int c = 0; c < PW; c++)
                    pooled[f][r][c] = conv_elem_t'($urandom);
    endtask

    task automatic test_reset();
        int errs;
        int idx [4];
        conv_elem_t val [4];
        idx = '{0, 99, 300, 999};
        val = '{8'd0, 8'd99, 8'd44, 8'd231};
        rst_n   = 1'b0;
        start   = 1'b1;
        s_start = 1'b1;
        for (int f = 0; f < NF; f++)
            for (int r = 0; r < PH; r++)
                for (int c = 0; c < PW; c++)
                    pooled[f][r][c] = conv_elem_t'((f * 100 + r * 10 + c) % 256);
        for (int i = 0; i < SNF * SPH * SPW; i++) s_pooled[i / 10][(i / 5) % 2][i % 5] = '0;
        #1;
        for (int k = 0; k < 4; k++) begin
            total++;
            if (flat_c[idx[k]] !== val[k]) begin
                bad++;
                $display("FAIL time0_comb[%0d]: got=%h want=%h", idx[k], flat_c[idx[k]], val[k]);
            end
        end
        @(posedge clk); #1;
        errs = 0;
        for (int i = 0; i < FL; i++) if (flat_r[i] !== 8'h00) errs++;
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL reset_reg: nonzero_elems=%0d want=0", errs);
        end
        total++;
        if (done !== 1'b0 || s_done !== 1'b0) begin
            bad++;
            $display("FAIL reset_done: got=%b/%b want=0/0", done, s_done);
        end
        start   = 1'b0;
        s_start = 1'b0;
        rst_n   = 1'b1;
        for (int i = 0; i < FL; i++) exp_r[i] = '0;
        for (int i = 0; i < SFL; i++) s_exp_r[i] = '0;
        @(posedge clk); #1;
        errs = 0;
        for (int i = 0; i < FL; i++) if (flat_r[i] !== exp_r[i]) errs++;
        total++;
        if (errs != 0 || done !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_idle: mismatches=%0d done=%b want 0/0", errs, done);
        end
    endtask

    task automatic test_comb_map();
        conv_elem_t m [FL];
        int errs, first;
        for (int n = 0; n < 3; n++) begin
            if (n > 0) randomize_pooled();
            #1;
            model_flat(pooled, m);
            errs = 0; first = -1;
            for (int i = 0; i < FL; i++)
                if (flat_c[i] !== m[i]) begin errs++; if (first < 0) first = i; end
            total++;
            if (errs != 0) begin
                bad++;
                $display("FAIL comb_map[%0d]: first_idx=%0d got=%h want=%h mismatches=%0d",
                         n, first, flat_c[first], m[first], errs);
            end
        end
        // Restore the reference ramp for the capture test.
        for (int f = 0; f < NF; f++)
            for (int r = 0; r < PH; r++)
                for (int c = 0; c < PW; c++)
                    pooled[f][r][c] = conv_elem_t'((f * 100 + r * 10 + c) % 256);
    endtask

    task automatic test_capture();
        int errs;
        start = 1'b1;
        model_flat(pooled, exp_r);
        @(posedge clk); #1;
        start = 1'b0;
        errs = 0;
        for (int i = 0; i < FL; i++) if (flat_r[i] !== exp_r[i]) errs++;
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL capture_reg: mismatches=%0d want=0 (e.g. [999] got=%h want=%h)",
                     errs, flat_r[999], exp_r[999]);
        end
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL capture_done: got=%b want=1", done);
        end
        @(posedge clk); #1;
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL capture_done_drop: got=%b want=0", done);
        end
    endtask

    task automatic test_hold();
        pooled[2][3][4] = 8'hAA;
        #1;
        total++;
        if (flat_c[234] !== 8'hAA) begin
            bad++;
            $display("FAIL hold_comb_234: got=%h want=aa", flat_c[234]);
        end
        total++;
        if (flat_r[234] !== exp_r[234]) begin
            bad++;
            $display("FAIL hold_reg_234_now: got=%h want=%h", flat_r[234], exp_r[234]);
        end
        @(posedge clk); #1;
        total++;
        if (flat_r[234] !== exp_r[234] || done !== 1'b0) begin
            bad++;
            $display("FAIL hold_reg_234_next: got=%h done=%b want=%h done=0", flat_r[234], done, exp_r[234]);
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        model_flat(pooled, exp_r);
        total++;
        if (flat_r[234] !== 8'hAA || done !== 1'b1) begin
            bad++;
            $display("FAIL hold_recapture_234: got=%h done=%b want=aa done=1", flat_r[234], done);
        end
    endtask

    task automatic test_random_capture();
        conv_elem_t m [FL];
        logic st;
        int errs;
        for (int n = 0; n < 12; n++) begin
            randomize_pooled();
            st = 1'($urandom_range(0, 1));
            start = st;
            model_flat(pooled, m);
            @(posedge clk); #1;
            if (st) exp_r = m;
            errs = 0;
            for (int i = 0; i < FL; i++) if (flat_r[i] !== exp_r[i]) errs++;
            total++;
            if (errs != 0 || done !== st) begin
                bad++;
                $display("FAIL random_capture[%0d]: mismatches=%0d done=%b want 0 mismatches done=%b",
                         n, errs, done, st);
            end
        end
        start = 1'b0;
    endtask

    task automatic test_back_to_back();
        int errs;
        start = 1'b1;
        for (int k = 0; k < 4; k++) begin
            randomize_pooled();
            model_flat(pooled, exp_r);
            @(posedge clk); #1;
            errs = 0;
            for (int i = 0; i < FL; i++) if (flat_r[i] !== exp_r[i]) errs++;
            total++;
            if (errs != 0 || done !== 1'b1) begin
                bad++;
                $display("FAIL back_to_back[%0d]: mismatches=%0d done=%b want 0 mismatches done=1", k, errs, done);
            end
        end
        start = 1'b0;
        randomize_pooled();
        @(posedge clk); #1;
        errs = 0;
        for (int i = 0; i < FL; i++) if (flat_r[i] !== exp_r[i]) errs++;
        total++;
        if (errs != 0 || done !== 1'b0) begin
            bad++;
            $display("FAIL back_to_back_end: mismatches=%0d done=%b want 0 mismatches done=0", errs, done);
        end
    endtask

    task automatic test_async_reset();
        conv_elem_t m [FL];
        int errs, cerrs;
        randomize_pooled();
        start = 1'b1;
        @(posedge clk); #1;
        model_flat(pooled, exp_r);
        #2;
        rst_n = 1'b0;
        #1;
        model_flat(pooled, m);
        errs = 0; cerrs = 0;
        for (int i = 0; i < FL; i++) begin
            if (flat_r[i] !== 8'h00) errs++;
            if (flat_c[i] !== m[i]) cerrs++;
        end
        total++;
        if (errs != 0 || done !== 1'b0) begin
            bad++;
            $display("FAIL async_reset_clear: nonzero=%0d done=%b want 0/0", errs, done);
        end
        total++;
        if (cerrs != 0) begin
            bad++;
            $display("FAIL async_reset_comb: mismatches=%0d want=0", cerrs);
        end
        @(posedge clk); #1;
        errs = 0;
        for (int i = 0; i < FL; i++) if (flat_r[i] !== 8'h00) errs++;
        total++;
        if (errs != 0 || done !== 1'b0) begin
            bad++;
            $display("FAIL start_during_reset: nonzero=%0d done=%b want 0/0", errs, done);
        end
        start = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < FL; i++) exp_r[i] = '0;
        for (int i = 0; i < SFL; i++) s_exp_r[i] = '0;
    endtask

    task automatic test_nonsquare();
        conv_elem_t m [SFL];
        int errs;
        int k;
        int base;
        base = int'($urandom_range(0, 255));
        k = 0;
        for (int f = 0; f < SNF; f++)
            for (int r = 0; r < SPH; r++)
                for (int c = 0; c < SPW; c++) begin
                    s_pooled[f][r][c] = conv_elem_t'((base + 7 * k) % 256);
                    k++;
                end
        #1;
        s_model_flat(s_pooled, m);
        errs = 0;
        for (int i = 0; i < SFL; i++) if (s_flat_c[i] !== m[i]) errs++;
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL nonsquare_comb: mismatches=%0d want=0", errs);
        end
        total++;
        if (s_flat_c[17] !== s_pooled[1][1][2]) begin
            bad++;
            $display("FAIL nonsquare_idx17: got=%h want=%h", s_flat_c[17], s_pooled[1][1][2]);
        end
        s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        s_exp_r = m;
        errs = 0;
        for (int i = 0; i < SFL; i++) if (s_flat_r[i] !== s_exp_r[i]) errs++;
        total++;
        if (errs != 0 || s_done !== 1'b1) begin
            bad++;
            $display("FAIL nonsquare_capture: mismatches=%0d done=%b want 0 mismatches done=1", errs, s_done);
        end
    endtask

    initial begin
        test_reset();
        test_comb_map();
        test_capture();
        test_hold();
        test_random_capture();
        test_back_to_back();
        test_async_reset();
        test_nonsquare();
        @(posedge clk); #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/flattening_module.md
FLATTENING_MODULE -- requirements
Module: flattening_module

Interface
REQ-001 Parameter NUM_FEATURES, default 10, number of pooled feature maps.
REQ-002 Parameter POOLED_HEIGHT, default 10, rows per pooled map.
REQ-003 Parameter POOLED_WIDTH, default 10, columns per pooled map.
REQ-004 Parameter FLATTENED_LENGTH, default NUM_FEATURES*POOLED_HEIGHT*POOLED_WIDTH, output vector length.
REQ-005 Parameter CONVOLUTION_DATA_WIDTH, default 8, element width in bits.
REQ-006 Clocking: one clock; reset is asynchronous and active-low.
REQ-007 clk  input  1  rising-edge clock.
REQ-008 rst_n  input  1  asynchronous active-low reset.
REQ-009 flatten_start  input  1  capture request, sampled on rising clk.
REQ-010 pooled_outfmap  input  CONVOLUTION_DATA_WIDTH x [NUM_FEATURES][POOLED_HEIGHT][POOLED_WIDTH]  pooled feature maps.
REQ-011 flattened_outfmap_c  output  CONVOLUTION_DATA_WIDTH x [FLATTENED_LENGTH]  combinational flattened vector.
REQ-012 flattened_outfmap  output  CONVOLUTION_DATA_WIDTH x [FLATTENED_LENGTH]  registered flattened vector.
REQ-013 flatten_done  output  1  one-cycle pulse: registered vector updated.

Function
REQ-014 Index map: element [f][r][c] SHALL go to index f*POOLED_HEIGHT*POOLED_WIDTH + r*POOLED_WIDTH + c (feature-major, then row, then column).
REQ-015 flattened_outfmap_c SHALL be the pure combinational map of pooled_outfmap per REQ-014, independent of flatten_start, clk and rst_n, zero cycles latency.
REQ-016 Elements SHALL be copied bit-exact; no arithmetic, sign change or saturation.
REQ-017 On a rising clk with rst_n high and flatten_start high, flattened_outfmap SHALL load flattened_outfmap_c; visible one cycle after the start sample.
REQ-018 With flatten_start low, flattened_outfmap SHALL hold its value.
REQ-019 flatten_done SHALL be high for exactly the cycle after each capture edge; flatten_start held high N cycles SHALL recapture every cycle and hold flatten_done high N cycles.
REQ-020 Input changes on the capture edge SHALL use the value present at that edge (standard setup); later changes SHALL not affect flattened_outfmap until the next capture.
REQ-021 FLATTENED_LENGTH not equal to NUM_FEATURES*POOLED_HEIGHT*POOLED_WIDTH SHALL be an elaboration-time error.

Reset
REQ-022 rst_n low SHALL asynchronously clear flattened_outfmap to all zeros and flatten_done to 0.
REQ-023 A flatten_start during reset SHALL be ignored; no capture occurs until the first rising clk after rst_n deasserts.
REQ-024 Reset SHALL not affect flattened_outfmap_c.

Structure
REQ-025 Shared package SHALL hold the default dimension constants, CONVOLUTION_DATA_WIDTH and the element typedef (logic [CONVOLUTION_DATA_WIDTH-1:0]).
REQ-026 One sub-module, flatten_map (purely combinational index permutation, REQ-014/015), SHALL be instantiated; the top adds the capture register and done flag.

Verification
REQ-027 Load [f][r][c] = (f*100+r*10+c) mod 256, defaults -> flattened_outfmap_c[i] = i mod 256 at time zero, e.g. [0]=0, [99]=99, [300]=44, [999]=231.
REQ-028 Same data, flatten_start high one cycle after reset -> next cycle flattened_outfmap equals flattened_outfmap_c, flatten_done = 1 for one cycle, then 0.
REQ-029 Change pooled_outfmap[2][3][4] to 8'hAA with flatten_start low -> flattened_outfmap_c[234]=8'hAA at once, flattened_outfmap[234] unchanged until next capture.
REQ-030 Assert rst_n low mid-operation, asynchronous to clk -> flattened_outfmap all zero and flatten_done 0 immediately, flattened_outfmap_c unchanged.
REQ-031 Non-square parameters (3 features, 2x5) with distinct values -> every index matches REQ-014 (e.g. [1][1][2] at index 17).
